// File: rtl/munoc_monitor_collector_pkg.sv
// ---------------------------------------------------------------------------
// munoc_monitor_collector_pkg
// Shared definitions for the NoC monitor collector: window FSM state
// encoding, read register indices and read port widths, plus a helper that
// packs the epoch/state status word.
// ---------------------------------------------------------------------------
package munoc_monitor_collector_pkg;

    // The numeric values are visible to software in the epoch register.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_CLEAR  = 2'd3
    } win_state_e;

    localparam int RD_DATA_W = 32;
    localparam int RD_ADDR_W = 8;

    localparam int ADDR_STATUS    = 0;
    localparam int ADDR_EPOCH     = 1;
    localparam int ADDR_SNAP_BASE = 2;

    // Epoch in the upper half, window state in the two LSBs.
    function automatic logic [RD_DATA_W-1:0] epoch_word(input logic [15:0] epoch,
                                                        input win_state_e st);
        return {epoch, 14'd0, st};
    endfunction

endpackage

// File: rtl/munoc_monitor_collector_if.sv
// ---------------------------------------------------------------------------
// munoc_monitor_collector_if
// Single-cycle register read port.
//   rd_req  : read request, one cycle per read (master -> slave)
//   rd_addr : register index (master -> slave)
//   rd_ack  : acknowledge, one cycle after rd_req (slave -> master)
//   rd_data : read data, held between acknowledges (slave -> master)
// ---------------------------------------------------------------------------
interface munoc_monitor_collector_if;
    import munoc_monitor_collector_pkg::*;

    logic                 rd_req;
    logic [RD_ADDR_W-1:0] rd_addr;
    logic                 rd_ack;
    logic [RD_DATA_W-1:0] rd_data;

    modport master (output rd_req, output rd_addr, input  rd_ack, input  rd_data);
    modport slave  (input  rd_req, input  rd_addr, output rd_ack, output rd_data);

endinterface

// File: rtl/munoc_monitor_window_fsm.sv
// ---------------------------------------------------------------------------
// munoc_monitor_window_fsm
// Bandwidth sampling window sequencer: IDLE -> COUNT (window_cycle cycles)
// -> SAMPLE -> CLEAR -> COUNT ...  A zero window length parks it in IDLE.
//   clk, rstnn    : clock, asynchronous active-low reset
//   window_cycle  : window length in cycles, 0 disables
//   state         : current FSM state
//   sample_en     : high for the one SAMPLE cycle
//   monitor_clear : registered clear pulse, high only in CLEAR
// ---------------------------------------------------------------------------
module munoc_monitor_window_fsm
    import munoc_monitor_collector_pkg::*;
#(
    parameter int BW_WINDOW = 16
) (
    input  logic                 clk,
    input  logic                 rstnn,
    input  logic [BW_WINDOW-1:0] window_cycle,
    output win_state_e           state,
    output logic                 sample_en,
    output logic                 monitor_clear
);

    win_state_e           state_q;
    logic [BW_WINDOW-1:0] win_cnt_q;
    logic                 monitor_clear_q;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q         <= ST_IDLE;
            win_cnt_q       <= '0;
            monitor_clear_q <= 1'b0;
        end else if (window_cycle == '0) begin
            // Disabling abandons the current window from any state.
            state_q         <= ST_IDLE;
            win_cnt_q       <= '0;
            monitor_clear_q <= 1'b0;
        end else begin
            monitor_clear_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q   <= ST_COUNT;
                    win_cnt_q <= '0;
                end
                ST_COUNT: begin
                    // Free-running increment: a shrunk window_cycle below the
                    // current count is only hit again after wrap-around.
                    win_cnt_q <= win_cnt_q + BW_WINDOW'(1);
                    if (win_cnt_q == window_cycle - BW_WINDOW'(1)) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    state_q         <= ST_CLEAR;
                    monitor_clear_q <= 1'b1;
                end
                ST_CLEAR: begin
                    state_q   <= ST_COUNT;
                    win_cnt_q <= '0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    win_cnt_q <= '0;
                end
            endcase
        end
    end

    assign state         = state_q;
    assign sample_en     = (state_q == ST_SAMPLE);
    assign monitor_clear = monitor_clear_q;

endmodule

// File: rtl/munoc_monitor_collector.sv
// ---------------------------------------------------------------------------
// munoc_monitor_collector
// Turns per-channel NoC monitor outputs into software-visible status:
// windowed bandwidth snapshots, an epoch counter, sticky write-1-to-clear
// timeout bits with an interrupt, and a one-cycle register read port.
//   clk, rstnn    : clock, asynchronous active-low reset
//   window_cycle  : sampling window length, 0 disables sampling
//   ch_timeout    : per-channel timeout levels from the monitors
//   ch_bandwidth  : per-channel bandwidth counts, channel i at [i*BW +: BW]
//   monitor_clear : one-cycle clear pulse to all monitors
//   clr_timeout   : per-channel clear strobes for the sticky timeout bits
//   rd_if         : register read port (slave side)
//   irq           : registered OR of the sticky timeout bits
// Registers: 0 = sticky timeouts, 1 = {epoch, state}, 2+i = snapshot of ch i.
// ---------------------------------------------------------------------------
module munoc_monitor_collector
    import munoc_monitor_collector_pkg::*;
#(
    parameter int NUM_CHANNEL  = 4,
    parameter int BW_BANDWIDTH = 16,
    parameter int BW_WINDOW    = 16
) (
    input  logic                                clk,
    input  logic                                rstnn,
    input  logic [BW_WINDOW-1:0]                window_cycle,
    input  logic [NUM_CHANNEL-1:0]              ch_timeout,
    input  logic [NUM_CHANNEL*BW_BANDWIDTH-1:0] ch_bandwidth,
    output logic                                monitor_clear,
    input  logic [NUM_CHANNEL-1:0]              clr_timeout,
    munoc_monitor_collector_if.slave            rd_if,
    output logic                                irq
);

    win_state_e state;
    logic       sample_en;

    munoc_monitor_window_fsm #(
        .BW_WINDOW (BW_WINDOW)
    ) u_window_fsm (
        .clk           (clk),
        .rstnn         (rstnn),
        .window_cycle  (window_cycle),
        .state         (state),
        .sample_en     (sample_en),
        .monitor_clear (monitor_clear)
    );

    logic [15:0]                            epoch_q, epoch_d;
    logic [NUM_CHANNEL-1:0]                 sts_q, sts_d;
    logic                                   irq_q, irq_d;
    logic                                   rd_ack_q, rd_ack_d;
    logic [RD_DATA_W-1:0]                   rd_data_q, rd_data_d;
    logic [RD_DATA_W-1:0]                   rd_word;
    logic [NUM_CHANNEL-1:0][RD_DATA_W-1:0]  snap_rd;

    // Per-channel snapshot register and its slice of the read decode; each
    // term is zero unless its own index is addressed, so they can be ORed.
    for (genvar gi = 0; gi < NUM_CHANNEL; gi++) begin : g_ch
        logic [BW_BANDWIDTH-1:0] snap_q, snap_d;

        always_comb begin
            snap_d = sample_en ? ch_bandwidth[gi*BW_BANDWIDTH +: BW_BANDWIDTH] : snap_q;
        end

        always_ff @(posedge clk or negedge rstnn) begin
            if (!rstnn) snap_q <= '0;
            else        snap_q <= snap_d;
        end

        assign snap_rd[gi] = (rd_if.rd_addr == RD_ADDR_W'(ADDR_SNAP_BASE + gi))
                             ? RD_DATA_W'(snap_q) : '0;
    end

    always_comb begin
        rd_word = '0;
        if (rd_if.rd_addr == RD_ADDR_W'(ADDR_STATUS)) begin
            rd_word = RD_DATA_W'(sts_q);
        end else if (rd_if.rd_addr == RD_ADDR_W'(ADDR_EPOCH)) begin
            rd_word = epoch_word(epoch_q, state);
        end
        for (int i = 0; i < NUM_CHANNEL; i++) begin
            rd_word = rd_word | snap_rd[i];
        end
    end

    always_comb begin
        epoch_d   = sample_en ? epoch_q + 16'd1 : epoch_q;
        // A new timeout wins over a simultaneous clear strobe.
        sts_d     = ch_timeout | (sts_q & ~clr_timeout);
        irq_d     = |sts_q;
        rd_ack_d  = rd_if.rd_req;
        rd_data_d = rd_if.rd_req ? rd_word : rd_data_q;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            epoch_q   <= '0;
            sts_q     <= '0;
            irq_q     <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            epoch_q   <= epoch_d;
            sts_q     <= sts_d;
            irq_q     <= irq_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign irq           = irq_q;
    assign rd_if.rd_ack  = rd_ack_q;
    assign rd_if.rd_data = rd_data_q;

endmodule

// File: tb/tb_munoc_monitor_collector.sv
module tb_munoc_monitor_collector;
    import munoc_monitor_collector_pkg::*;

    localparam int NCH = 4;
    localparam int BWB = 16;
    localparam int BWW = 16;

    logic               clk;
    logic               rstnn;
    logic [BWW-1:0]     window_cycle;
    logic [NCH-1:0]     ch_timeout;
    logic [NCH-1:0]     clr_timeout;
    logic [NCH*BWB-1:0] ch_bandwidth;
    logic               monitor_clear;
    logic               irq;

    munoc_monitor_collector_if rd_if();

    munoc_monitor_collector #(
        .NUM_CHANNEL  (NCH),
        .BW_BANDWIDTH (BWB),
        .BW_WINDOW    (BWW)
    ) dut (
        .clk           (clk),
        .rstnn         (rstnn),
        .window_cycle  (window_cycle),
        .ch_timeout    (ch_timeout),
        .ch_bandwidth  (ch_bandwidth),
        .monitor_clear (monitor_clear),
        .clr_timeout   (clr_timeout),
        .rd_if         (rd_if),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_epoch = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    rd_exp_t mon_e;

    // Read scoreboard: every acknowledge pops the oldest expected read.
    always begin
        @(posedge clk);
        #1;
        if (rd_if.rd_ack === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected_ack got_data=%08h required=no_ack", rd_if.rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                $display("rd addr=%0d data=%08h exp=%08h", mon_e.addr, rd_if.rd_data, mon_e.data);
                if (rd_if.rd_data !== mon_e.data) begin
                    bad++;
                    $display("FAIL rd_data addr=%0d got=%08h required=%08h",
                             mon_e.addr, rd_if.rd_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        rd_exp_t x;
        x.addr = a;
        x.data = e;
        exp_q.push_back(x);
        rd_if.rd_req  = 1'b1;
        rd_if.rd_addr = a;
        tick();
        rd_if.rd_req  = 1'b0;
    endtask

    // Every outstanding read must have been acknowledged by now.
    task automatic drain(input string name);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_ack got=%0d_pending required=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic wait_clear(input string name, input int max, input int want);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < max) begin
            tick();
            n++;
            if (monitor_clear === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || n != want) begin
            bad++;
            $display("FAIL %s_clear_latency got=%0d seen=%0b required=%0d", name, n, seen, want);
        end
    endtask

    task automatic test_reset();
        rstnn         = 1'b0;
        window_cycle  = '0;
        ch_timeout    = '0;
        clr_timeout   = '0;
        ch_bandwidth  = '0;
        rd_if.rd_req  = 1'b0;
        rd_if.rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({monitor_clear, irq, rd_if.rd_ack} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%03b required=000", {monitor_clear, irq, rd_if.rd_ack});
        end
        total++;
        if (rd_if.rd_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd_data got=%08h required=00000000", rd_if.rd_data);
        end
        rstnn = 1'b1;
        tick(2);
        total++;
        if (monitor_clear !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_clear got=%0b required=0", monitor_clear);
        end
        rd(8'd1, 32'h0000_0000);
        rd(8'd0, 32'h0000_0000);
        drain("reset");
    endtask

    task automatic test_window();
        window_cycle = 16'd10;
        for (int i = 1; i <= 36; i++) begin
            tick();
            total++;
            if (monitor_clear !== 1'((i % 12) == 0)) begin
                bad++;
                $display("FAIL window_clear cycle=%0d got=%0b required=%0b",
                         i, monitor_clear, (i % 12) == 0);
            end
        end
        rd(8'd1, 32'h0003_0003);  // sampled while in CLEAR
        rd(8'd1, 32'h0003_0001);  // sampled while in COUNT
        drain("window");
    endtask

    task automatic test_snapshot();
        window_cycle = '0;
        tick();
        ch_bandwidth = {16'hDDDD, 16'h1234, 16'hBBBB, 16'hAAAA};
        window_cycle = 16'd3;
        wait_clear("snapshot", 20, 5);
        ch_bandwidth[2*BWB +: BWB] = 16'h5678;
        tick(4);                  // FSM now in SAMPLE
        rd(8'd4, 32'h0000_1234);  // read coincides with SAMPLE: old value
        rd(8'd4, 32'h0000_5678);
        rd(8'd2, 32'h0000_AAAA);
        rd(8'd3, 32'h0000_BBBB);
        rd(8'd5, 32'h0000_DDDD);
        rd(8'd9, 32'h0000_0000);
        rd(8'd6, 32'h0000_0000);
        rd(8'hFF, 32'h0000_0000);
        drain("snapshot");
        window_cycle = '0;
        tick();
    endtask

    task automatic test_timeout();
        ch_timeout = 4'b0010;
        tick();
        ch_timeout = '0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL timeout_irq_early got=%0b required=0", irq);
        end
        tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL timeout_irq_set got=%0b required=1", irq);
        end
        rd(8'd0, 32'h0000_0002);

        clr_timeout = 4'b0010;
        tick();
        clr_timeout = '0;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL timeout_irq_clr_early got=%0b required=1", irq);
        end
        tick();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL timeout_irq_clr got=%0b required=0", irq);
        end
        rd(8'd0, 32'h0000_0000);

        ch_timeout = 4'b0010;
        tick();
        ch_timeout  = 4'b0010;
        clr_timeout = 4'b0010;
        tick();
        ch_timeout  = '0;
        clr_timeout = '0;
        tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL timeout_set_wins_irq got=%0b required=1", irq);
        end
        rd(8'd0, 32'h0000_0002);

        ch_timeout = 4'b1001;
        tick();
        ch_timeout  = '0;
        clr_timeout = 4'b0001;
        tick();
        clr_timeout = '0;
        rd(8'd0, 32'h0000_000A);
        drain("timeout");
    endtask

    task automatic test_reset_mid();
        window_cycle = 16'd8;
        tick();       // COUNT, win_cnt 0
        tick(6);      // win_cnt 6
        total++;
        if (irq !== 1'b1 || rd_if.rd_data !== 32'h0000_000A) begin
            bad++;
            $display("FAIL resetmid_pre got=irq%0b_data%08h required=irq1_data0000000a",
                     irq, rd_if.rd_data);
        end
        #2;
        rstnn = 1'b0;
        #1;
        total++;
        if ({monitor_clear, irq, rd_if.rd_ack} !== 3'b000 || rd_if.rd_data !== 32'h0) begin
            bad++;
            $display("FAIL resetmid_async got=%03b_%08h required=000_00000000",
                     {monitor_clear, irq, rd_if.rd_ack}, rd_if.rd_data);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rstnn = 1'b1;
        mon_e.addr = 8'd1;
        mon_e.data = 32'h0;
        exp_q.push_back(mon_e);
        rd_if.rd_req  = 1'b1;
        rd_if.rd_addr = 8'd1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) rd_if.rd_req = 1'b0;
            total++;
            if (monitor_clear !== 1'(i == 10)) begin
                bad++;
                $display("FAIL resetmid_clear cycle=%0d got=%0b required=%0b",
                         i, monitor_clear, i == 10);
            end
        end
        drain("resetmid");
        exp_epoch = 1;
        window_cycle = '0;
        tick();
    endtask

    task automatic test_disable();
        int pulses = 0;
        window_cycle = 16'd10;
        tick(5);
        window_cycle = '0;
        repeat (15) begin
            tick();
            if (monitor_clear !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL disable_no_clear got=%0d required=0", pulses);
        end
        rd(8'd1, {16'(exp_epoch), 16'h0000});
        window_cycle = 16'd5;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total++;
            if (monitor_clear !== 1'(i == 7)) begin
                bad++;
                $display("FAIL disable_restart_clear cycle=%0d got=%0b required=%0b",
                         i, monitor_clear, i == 7);
            end
        end
        exp_epoch++;
        window_cycle = '0;
        tick();
        rd(8'd1, {16'(exp_epoch), 16'h0000});
        drain("disable");
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [3];
        want[0] = 32'h0000_0005;
        want[1] = {16'(exp_epoch), 16'h0000};
        want[2] = 32'h0000_AAAA;
        ch_timeout = 4'b0101;
        tick();
        ch_timeout = '0;
        for (int i = 0; i < 3; i++) begin
            mon_e.addr = 8'(i);
            mon_e.data = want[i];
            exp_q.push_back(mon_e);
            rd_if.rd_req  = 1'b1;
            rd_if.rd_addr = 8'(i);
            tick();
            if (i > 0) begin
                total++;
                if (rd_if.rd_ack !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ack cycle=%0d got=%0b required=1", i, rd_if.rd_ack);
                end
            end
        end
        rd_if.rd_req = 1'b0;
        tick();
        total++;
        if (rd_if.rd_ack !== 1'b0 || rd_if.rd_data !== 32'h0000_AAAA) begin
            bad++;
            $display("FAIL b2b_hold got=ack%0b_%08h required=ack0_0000aaaa",
                     rd_if.rd_ack, rd_if.rd_data);
        end
        tick();
        total++;
        if (rd_if.rd_data !== 32'h0000_AAAA) begin
            bad++;
            $display("FAIL b2b_hold2 got=%08h required=0000aaaa", rd_if.rd_data);
        end
        drain("b2b");
    endtask

    task automatic test_epoch_wrap();
        force dut.epoch_d = 16'hFFFF;
        tick();
        release dut.epoch_d;
        rd(8'd1, 32'hFFFF_0000);
        window_cycle = 16'd2;
        wait_clear("wrap", 20, 4);
        window_cycle = '0;
        tick();
        rd(8'd1, 32'h0000_0000);
        drain("wrap");
    endtask

    initial begin
        test_reset();
        test_window();
        test_snapshot();
        test_timeout();
        test_reset_mid();
        test_disable();
        test_back_to_back();
        test_epoch_wrap();
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
